bcd_countdown_timer: RTL and testbench
======================================

Name: bcd_countdown_timer

Overview:
Countdown timer; the consuming end of the hundredth-of-second tick interface.
- Loads a preset in whole seconds (00-99) and decrements a 4-digit BCD count (SS.hh) by one on each hundredth tick while running.
- Drives device_running back to the tick generator, so the generator only advances while the timer runs.
- Flags expiry and the low-time condition for the display and buzzer logic.

Parameters:
LOW_WARN_SEC, 5, warn asserted while remaining whole seconds < LOW_WARN_SEC and count nonzero (0 disables warn).

Ports:
CLK  input  1  system clock.
RESET  input  1  asynchronous active-low reset.
tick  input  1  single-cycle hundredth-of-second pulse from the tick generator.
load  input  1  single-cycle pulse; load preset.
start_stop  input  1  single-cycle pulse; start/pause/resume.
preset_sec_tens  input  4  BCD preset, tens of seconds.
preset_sec_ones  input  4  BCD preset, units of seconds.
sec_tens  output  4  BCD count digit.
sec_ones  output  4  BCD count digit.
hund_tens  output  4  BCD count digit.
hund_ones  output  4  BCD count digit.
device_running  output  1  high in RUNNING; feeds the tick generator enable.
done  output  1  high in EXPIRED.
warn  output  1  low-time indication.

Behaviour:
Reset (RESET low, asynchronous):
- All digits 0, state IDLE.
- device_running, done, warn all 0.

States: IDLE, RUNNING, PAUSED, EXPIRED. All outputs are registered or decoded directly from state/count registers; no input-to-output combinational path.

load (any state except RUNNING):
- Count <= preset_sec_tens:preset_sec_ones.00; next state IDLE; done clears the next cycle.
- Preset digits > 9 saturate to 9 (e.g. 4'hC loads as 9).
- load in RUNNING is ignored.

start_stop:
- IDLE -> RUNNING only if count is nonzero; with count 00.00 it stays IDLE.
- RUNNING -> PAUSED; PAUSED -> RUNNING.
- EXPIRED: ignored.

tick in RUNNING:
- BCD decrement by one hundredth on the same edge.
- A digit at 0 wraps to 9 and borrows from the next digit; e.g. 10.00 -> 09.99, 01.00 -> 00.99.
- At count 00.01: count goes to 00.00 and the state goes to EXPIRED on the same edge. done and device_running=0 are visible the cycle after that edge.

tick outside RUNNING: ignored; count holds.

Simultaneous events:
- load + start_stop in non-RUNNING: load wins; start_stop is dropped and the state is IDLE.
- tick + start_stop in RUNNING: decrement applied and state goes to PAUSED.
- tick + start_stop at 00.01: EXPIRED wins.

warn:
- High in RUNNING or PAUSED when (sec_tens*10 + sec_ones) < LOW_WARN_SEC and count != 00.00.
- Low in IDLE and EXPIRED.

Count never underflows below 00.00.

Optional Feature:
Macro AUTO_RELOAD_EN.
- Defined: on the tick that reaches 00.00, the count reloads from the (saturated) preset inputs and the state stays RUNNING. done is a one-cycle pulse on the following cycle; EXPIRED is unused. If the preset is 00, the timer goes to EXPIRED as in the non-reload case.
- Undefined: behaviour as above; done is a level held until load or reset.

Test Plan:
- Reset mid-count at 07.42 -> all digits 0, device_running=0, done=0 on the asynchronous edge, without waiting for CLK.
- Preset 02, load, start_stop, 200 ticks -> passes 01.00 -> 00.99; after tick 200 count 00.00, done=1 and device_running=0 one cycle later; further ticks leave 00.00.
- Preset 12, load, start, 150 ticks -> 10.50; start_stop -> PAUSED; 20 ticks -> still 10.50; start_stop + 1 tick -> 10.49.
- Presets 4'hF / 4'hA, load -> count 99.00; start, 1 tick -> 98.99; load in RUNNING -> count unchanged.
- LOW_WARN_SEC=5, preset 06, run -> warn rises at 04.99, stays high through 00.01, low at 00.00 in EXPIRED.
- AUTO_RELOAD_EN, preset 01, run 100 ticks -> count 01.00, device_running stays 1, done high exactly one cycle; preset 00 with load + start_stop -> stays IDLE.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// BCD countdown timer (SS.hh) driven by hundredth-of-second ticks; gates the tick generator via device_running.
// Optional macro AUTO_RELOAD_EN: reload from preset on reaching 00.00 instead of expiring.
module bcd_countdown_timer #(
    parameter int LOW_WARN_SEC = 5
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       tick,
    input  logic       load,
    input  logic       start_stop,
    input  logic [3:0] preset_sec_tens,
    input  logic [3:0] preset_sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] hund_tens,
    output logic [3:0] hund_ones,
    output logic       device_running,
    output logic       done,
    output logic       warn,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUNNING = 2'd1,
        S_PAUSED  = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    localparam logic [7:0] WARN_LIM = 8'(LOW_WARN_SEC);

    state_t      state;
    logic [15:0] count;
    logic [15:0] dec_count;
    logic [15:0] preset_count;
    logic [3:0]  sat_tens;
    logic [3:0]  sat_ones;
    logic        count_nz;
    logic        at_one;
    logic [6:0]  secs;

    assign sat_tens     = (preset_sec_tens > 4'd9) ? 4'd9 : preset_sec_tens;
    assign sat_ones     = (preset_sec_ones > 4'd9) ? 4'd9 : preset_sec_ones;
    assign preset_count = {sat_tens, sat_ones, 8'h00};
    assign count_nz     = (count != 16'h0000);
    assign at_one       = (count == 16'h0001);

    // Digit-wise borrow chain; the top digit clamps at 0 so the count cannot underflow.
    always_comb begin
        dec_count = count;
        if (count[3:0] != 4'd0) begin
            dec_count[3:0] = count[3:0] - 4'd1;
        end else begin
            dec_count[3:0] = 4'd9;
            if (count[7:4] != 4'd0) begin
                dec_count[7:4] = count[7:4] - 4'd1;
            end else begin
                dec_count[7:4] = 4'd9;
                if (count[11:8] != 4'd0) begin
                    dec_count[11:8] = count[11:8] - 4'd1;
                end else begin
                    dec_count[11:8] = 4'd9;
                    if (count[15:12] != 4'd0)
                        dec_count[15:12] = count[15:12] - 4'd1;
                    else
                        dec_count = 16'h0000;
                end
            end
        end
    end

`ifdef AUTO_RELOAD_EN
    logic done_pulse;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= S_IDLE;
            count <= 16'h0000;
`ifdef AUTO_RELOAD_EN
            done_pulse <= 1'b0;
`endif
        end else begin
`ifdef AUTO_RELOAD_EN
            done_pulse <= 1'b0;
`endif
            case (state)
                S_RUNNING: begin
                    if (tick) begin
                        // Expiry takes priority over a simultaneous start_stop.
                        if (at_one) begin
`ifdef AUTO_RELOAD_EN
                            if (preset_count != 16'h0000) begin
                                count      <= preset_count;
                                done_pulse <= 1'b1;
                            end else begin
                                count <= 16'h0000;
                                state <= S_EXPIRED;
                            end
`else
                            count <= 16'h0000;
                            state <= S_EXPIRED;
`endif
                        end else begin
                            count <= dec_count;
                            if (start_stop)
                                state <= S_PAUSED;
                        end
                    end else if (start_stop) begin
                        state <= S_PAUSED;
                    end
                end
                default: begin
                    if (load) begin
                        count <= preset_count;
                        state <= S_IDLE;
                    end else if (start_stop) begin
                        if (state == S_PAUSED)
                            state <= S_RUNNING;
                        else if (state == S_IDLE && count_nz)
                            state <= S_RUNNING;
                    end
                end
            endcase
        end
    end

    assign sec_tens  = count[15:12];
    assign sec_ones  = count[11:8];
    assign hund_tens = count[7:4];
    assign hund_ones = count[3:0];
    assign state_dbg = state;

    assign device_running = (state == S_RUNNING);
`ifdef AUTO_RELOAD_EN
    assign done = (state == S_EXPIRED) || done_pulse;
`else
    assign done = (state == S_EXPIRED);
`endif

    assign secs = 7'(sec_tens) * 7'd10 + 7'(sec_ones);
    assign warn = ((state == S_RUNNING) || (state == S_PAUSED)) && count_nz
                  && ({1'b0, secs} < WARN_LIM);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: vector table for single-cycle events plus long tick sequences.
module tb_bcd_countdown_timer;

    localparam int LOW = 5;

    logic       CLK;
    logic       RESET;
    logic       tick;
    logic       load;
    logic       start_stop;
    logic [3:0] preset_sec_tens;
    logic [3:0] preset_sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] hund_tens;
    logic [3:0] hund_ones;
    logic       device_running;
    logic       done;
    logic       warn;
    logic [1:0] state_dbg;

    int total_cnt = 0;
    int bad_cnt   = 0;
    logic [15:0] exp_q[$];

    bcd_countdown_timer #(.LOW_WARN_SEC(LOW)) dut (
        .CLK(CLK), .RESET(RESET), .tick(tick), .load(load), .start_stop(start_stop),
        .preset_sec_tens(preset_sec_tens), .preset_sec_ones(preset_sec_ones),
        .sec_tens(sec_tens), .sec_ones(sec_ones), .hund_tens(hund_tens), .hund_ones(hund_ones),
        .device_running(device_running), .done(done), .warn(warn), .state_dbg(state_dbg)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic t, l, s;
        logic [3:0] pt, po;
        logic [15:0] cnt;
        logic [1:0] st;
        logic dn, wr;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [15:0] count_now();
        return {sec_tens, sec_ones, hund_tens, hund_ones};
    endfunction

    function automatic logic [15:0] to_bcd(input int h);
        int s, hh;
        s  = h / 100;
        hh = h % 100;
        return {4'(s / 10), 4'(s % 10), 4'(hh / 10), 4'(hh % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic t, input logic l, input logic s);
        tick = t; load = l; start_stop = s;
        @(posedge CLK);
        @(negedge CLK);
        tick = 1'b0; load = 1'b0; start_stop = 1'b0;
    endtask

    task automatic set_preset(input logic [3:0] pt, input logic [3:0] po);
        preset_sec_tens = pt;
        preset_sec_ones = po;
    endtask

    // Ticks while RUNNING from start_h hundredths; integer model of the remaining time.
    task automatic run_ticks(input int start_h, input int n);
        int rem;
        logic [15:0] e;
        for (int i = 1; i <= n; i++) begin
            rem = start_h - i;
            if (rem < 0) rem = 0;
            exp_q.push_back(to_bcd(rem));
            step(1'b1, 1'b0, 1'b0);
            e = exp_q.pop_front();
            check("tick_count", 32'(count_now()), 32'(e));
            check("tick_state", 32'(state_dbg), (rem > 0) ? 32'd1 : 32'd3);
            check("tick_done", 32'(done), (rem == 0) ? 32'd1 : 32'd0);
            check("tick_running", 32'(device_running), (rem > 0) ? 32'd1 : 32'd0);
            check("tick_warn", 32'(warn), (rem > 0 && rem < LOW * 100) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        RESET = 1'b0;
        tick = 1'b0; load = 1'b0; start_stop = 1'b0;
        set_preset(4'd0, 4'd0);

        vecs[0]  = '{1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 16'h0000, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 16'h0000, 2'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 4'hF, 4'hA, 16'h9900, 2'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 4'hF, 4'hA, 16'h9900, 2'd1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 4'hF, 4'hA, 16'h9899, 2'd1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 4'h1, 4'h2, 16'h9899, 2'd1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 4'h1, 4'h2, 16'h9898, 2'd2, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 4'h1, 4'h2, 16'h9898, 2'd2, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 4'h0, 4'h3, 16'h0300, 2'd0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 4'h0, 4'h3, 16'h0300, 2'd1, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 4'h0, 4'h3, 16'h0300, 2'd2, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 16'h0000, 2'd0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 16'h0000, 2'd0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'hC, 16'h0900, 2'd0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 4'h0, 4'hC, 16'h0900, 2'd1, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 4'h0, 4'hC, 16'h0899, 2'd1, 1'b0, 1'b0};

        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        check("rst_count", 32'(count_now()), 32'h0000);
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_running", 32'(device_running), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_warn", 32'(warn), 32'd0);

        for (int i = 0; i < 16; i++) begin
            set_preset(vecs[i].pt, vecs[i].po);
            step(vecs[i].t, vecs[i].l, vecs[i].s);
            check($sformatf("vec%0d_count", i), 32'(count_now()), 32'(vecs[i].cnt));
            check($sformatf("vec%0d_state", i), 32'(state_dbg), 32'(vecs[i].st));
            check($sformatf("vec%0d_running", i), 32'(device_running), 32'(vecs[i].st == 2'd1));
            check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].dn));
            check($sformatf("vec%0d_warn", i), 32'(warn), 32'(vecs[i].wr));
        end
        step(1'b0, 1'b0, 1'b1);
        check("pause_after_table", 32'(state_dbg), 32'd2);

`ifndef AUTO_RELOAD_EN
        // 02.00 down to expiry, then idle ticks must hold 00.00.
        set_preset(4'd0, 4'd2);
        step(1'b0, 1'b1, 1'b0);
        check("p02_load", 32'(count_now()), 32'h0200);
        step(1'b0, 1'b0, 1'b1);
        run_ticks(200, 200);
        run_ticks(0, 3);
        step(1'b0, 1'b0, 1'b1);
        check("expired_ss_state", 32'(state_dbg), 32'd3);
        check("expired_ss_done", 32'(done), 32'd1);
`endif

        // Pause holds the count; resume and decrement.
        set_preset(4'd1, 4'd2);
        step(1'b0, 1'b1, 1'b0);
        check("p12_load_count", 32'(count_now()), 32'h1200);
        check("p12_load_done", 32'(done), 32'd0);
        step(1'b0, 1'b0, 1'b1);
        run_ticks(1200, 150);
        step(1'b0, 1'b0, 1'b1);
        check("pause_state", 32'(state_dbg), 32'd2);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);
        check("pause_hold_count", 32'(count_now()), 32'h1050);
        check("pause_hold_running", 32'(device_running), 32'd0);
        step(1'b0, 1'b0, 1'b1);
        check("resume_state", 32'(state_dbg), 32'd1);
        step(1'b1, 1'b0, 1'b0);
        check("resume_tick_count", 32'(count_now()), 32'h1049);
        step(1'b0, 1'b0, 1'b1);

`ifndef AUTO_RELOAD_EN
        // Warn window over a full 06.00 run.
        set_preset(4'd0, 4'd6);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        run_ticks(600, 600);
`endif

        // Asynchronous reset at 07.42, away from any clock edge.
        set_preset(4'd0, 4'd8);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        run_ticks(800, 58);
        #2 RESET = 1'b0;
        #1;
        check("async_rst_count", 32'(count_now()), 32'h0000);
        check("async_rst_running", 32'(device_running), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_state", 32'(state_dbg), 32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);

`ifdef AUTO_RELOAD_EN
        set_preset(4'd0, 4'd1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 99; i++) step(1'b1, 1'b0, 1'b0);
        check("ar_pre_count", 32'(count_now()), 32'h0001);
        check("ar_pre_done", 32'(done), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        check("ar_reload_count", 32'(count_now()), 32'h0100);
        check("ar_reload_running", 32'(device_running), 32'd1);
        check("ar_reload_done", 32'(done), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        check("ar_done_pulse_end", 32'(done), 32'd0);
        check("ar_hold_count", 32'(count_now()), 32'h0100);
        check("ar_hold_running", 32'(device_running), 32'd1);
        step(1'b0, 1'b0, 1'b1);
        set_preset(4'd0, 4'd0);
        step(1'b0, 1'b1, 1'b1);
        check("ar_p00_state", 32'(state_dbg), 32'd0);
        check("ar_p00_count", 32'(count_now()), 32'h0000);
        step(1'b0, 1'b0, 1'b1);
        check("ar_p00_stay_idle", 32'(state_dbg), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
